binary_clock_ws2812: RTL

//   Display-side consumer of the binary clock's 14-bit packed time word.
//   On each refresh strobe it snapshots the count, maps every bit to one pixel of the
//   16-pixel (4x4) WS2812 matrix, then serialises 16 x 24-bit GRB words onto a single

---
 rtl/binary_clock_pkg.sv | 20 ++
 rtl/ws2812_bit_tx.sv | 75 +++++++
 rtl/binary_clock_ws2812.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/binary_clock_pkg.sv
// rtl/binary_clock_pkg.sv - shared widths, FSM encoding and ns-to-cycle helper for the WS2812 clock display
package binary_clock_pkg;

  localparam int COUNT_W = 14;
  localparam int GRB_W   = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HIGH,
    ST_LOW,
    ST_LATCH
  } state_e;

  // Round-to-nearest conversion; 64-bit math keeps CLK_HZ*ns from overflowing.
  function automatic int ns_to_cyc(input longint clk_hz, input longint ns);
    return int'((clk_hz * ns + 500_000_000) / 1_000_000_000);
  endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// rtl/ws2812_bit_tx.sv - one WS2812 bit period: high for T0H/T1H cycles, low for the rest of TBIT
module ws2812_bit_tx #(
  parameter int T0H_CYC  = 5,
  parameter int T1H_CYC  = 10,
  parameter int TBIT_CYC = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic bit_val,
  output logic dout,
  output logic high_end,
  output logic pre_done,
  output logic bit_done
);

  localparam int CW = $clog2(TBIT_CYC);
  localparam logic [CW-1:0] LAST_CNT = CW'(TBIT_CYC - 1);
  localparam logic [CW-1:0] PRE_CNT  = CW'(TBIT_CYC - 2);
  localparam logic [CW-1:0] H0_CNT   = CW'(T0H_CYC);
  localparam logic [CW-1:0] H1_CNT   = CW'(T1H_CYC);

  logic          active_q, active_d;
  logic          hi_q, hi_d;
  logic          dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] high_cnt;

  assign high_cnt = hi_q ? H1_CNT : H0_CNT;
  assign cnt_nxt  = cnt_q + 1'b1;

  always_comb begin
    active_d = active_q;
    hi_d     = hi_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    // A go in the last cycle of a bit restarts seamlessly, so bits abut with no gap.
    if (go) begin
      active_d = 1'b1;
      hi_d     = bit_val;
      cnt_d    = '0;
      dout_d   = 1'b1;
    end else if (active_q) begin
      if (cnt_q == LAST_CNT) begin
        active_d = 1'b0;
        dout_d   = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d  = cnt_nxt;
        dout_d = (cnt_nxt < high_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      hi_q     <= 1'b0;
      dout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      hi_q     <= hi_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout     = dout_q;
  assign high_end = active_q && (cnt_q == high_cnt - 1'b1);
  assign pre_done = active_q && (cnt_q == PRE_CNT);
  assign bit_done = active_q && (cnt_q == LAST_CNT);

endmodule

// File: rtl/binary_clock_ws2812.sv
// rtl/binary_clock_ws2812.sv - snapshots the packed time word and streams it as 16 GRB pixels to a WS2812 matrix
module binary_clock_ws2812
  import binary_clock_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int T0H_NS     = 400,
  parameter int T1H_NS     = 800,
  parameter int TBIT_NS    = 1250,
  parameter int TLATCH_US  = 80,
  parameter int NUM_PIXELS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               refresh,
  input  logic [COUNT_W-1:0] count,
  input  logic [GRB_W-1:0]   on_grb,
  input  logic [GRB_W-1:0]   off_grb,
  output logic               dout,
  output logic               busy,
  output logic               done
);

  localparam int T0H_CYC   = ns_to_cyc(CLK_HZ, T0H_NS);
  localparam int T1H_CYC   = ns_to_cyc(CLK_HZ, T1H_NS);
  localparam int TBIT_CYC  = ns_to_cyc(CLK_HZ, TBIT_NS);
  localparam int LATCH_CYC = int'(longint'(CLK_HZ) * longint'(TLATCH_US) / 1_000_000);
  localparam int PW        = $clog2(NUM_PIXELS);
  localparam int LW        = $clog2(LATCH_CYC);
  localparam int BW        = $clog2(GRB_W);

  localparam logic [PW-1:0] LAST_PIX   = PW'(NUM_PIXELS - 1);
  localparam logic [LW-1:0] LATCH_PRE  = LW'(LATCH_CYC - 2);
  localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYC - 1);
  localparam logic [BW-1:0] MSB_IDX    = BW'(GRB_W - 1);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_sh_q, count_sh_d;
  logic [GRB_W-1:0]   on_sh_q, on_sh_d;
  logic [GRB_W-1:0]   off_sh_q, off_sh_d;
  logic [GRB_W-1:0]   shift_q, shift_d;
  logic [BW-1:0]      bit_idx_q, bit_idx_d;
  logic [PW-1:0]      pixel_q, pixel_d;
  logic [LW-1:0]      latch_cnt_q, latch_cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic                  go;
  logic                  bit_val;
  logic                  high_end;
  logic                  pre_done;
  logic                  bit_done;
  logic [NUM_PIXELS-1:0] pix_bits;
  logic [GRB_W-1:0]      load_colour;

  // Pixels above the count width see zero-extended bits and so always render off.
  assign pix_bits    = NUM_PIXELS'(count_sh_q);
  assign load_colour = pix_bits[pixel_q] ? on_sh_q : off_sh_q;

  always_comb begin
    state_d     = state_q;
    count_sh_d  = count_sh_q;
    on_sh_d     = on_sh_q;
    off_sh_d    = off_sh_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    pixel_d     = pixel_q;
    latch_cnt_d = latch_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    go          = 1'b0;
    bit_val     = shift_q[GRB_W-2];
    case (state_q)
      ST_IDLE: begin
        if (refresh) begin
          count_sh_d = count;
          on_sh_d    = on_grb;
          off_sh_d   = off_grb;
          pixel_d    = '0;
          busy_d     = 1'b1;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        go        = 1'b1;
        bit_val   = load_colour[GRB_W-1];
        shift_d   = load_colour;
        bit_idx_d = MSB_IDX;
        state_d   = ST_HIGH;
      end
      ST_HIGH: begin
        if (high_end) begin
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        // LOAD steals the final low cycle of a pixel's last bit so pixels abut.
        if (bit_idx_q == '0) begin
          if (pixel_q == LAST_PIX) begin
            if (bit_done) begin
              latch_cnt_d = '0;
              state_d     = ST_LATCH;
            end
          end else if (pre_done) begin
            pixel_d = pixel_q + 1'b1;
            state_d = ST_LOAD;
          end
        end else if (bit_done) begin
          go        = 1'b1;
          shift_d   = shift_q << 1;
          bit_idx_d = bit_idx_q - 1'b1;
          state_d   = ST_HIGH;
        end
      end
      ST_LATCH: begin
        latch_cnt_d = latch_cnt_q + 1'b1;
        if (latch_cnt_q == LATCH_PRE) begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
        if (latch_cnt_q == LATCH_LAST) begin
          latch_cnt_d = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      count_sh_q  <= '0;
      on_sh_q     <= '0;
      off_sh_q    <= '0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      pixel_q     <= '0;
      latch_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_sh_q  <= count_sh_d;
      on_sh_q     <= on_sh_d;
      off_sh_q    <= off_sh_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      pixel_q     <= pixel_d;
      latch_cnt_q <= latch_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  ws2812_bit_tx #(
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .TBIT_CYC (TBIT_CYC)
  ) u_bit_tx (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .bit_val  (bit_val),
    .dout     (dout),
    .high_end (high_end),
    .pre_done (pre_done),
    .bit_done (bit_done)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule
